// File: rtl/inst_stream_constraint_if.sv
// Fetch-bundle and verdict signals between the instruction source and inst_stream_constraint.
// The master drives the bundle and stall; the slave returns legality and stream state.
interface inst_stream_constraint_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned MAX_INSTS   = 16,
  parameter int unsigned MAX_NOP_RUN = 4
);
  localparam int unsigned IW = $clog2(MAX_INSTS + 1);
  localparam int unsigned NW = $clog2(MAX_NOP_RUN + 1);

  logic [32*FETCH_WIDTH-1:0] instructions;
  logic                      stall_in;
  logic [FETCH_WIDTH-1:0]    slot_legal;
  logic                      constraint_ok;
  logic [1:0]                phase;
  logic [IW-1:0]             issued_cnt;
  logic [NW-1:0]             nop_run;
  logic                      done;

  modport master (
    output instructions, stall_in,
    input  slot_legal, constraint_ok, phase, issued_cnt, nop_run, done
  );

  modport slave (
    input  instructions, stall_in,
    output slot_legal, constraint_ok, phase, issued_cnt, nop_run, done
  );
endinterface

// File: rtl/inst_stream_constraint.sv
// Instruction-stream constraint: per-slot RISC-V subset legality plus stream rules
// (instruction budget, bounded NOP runs, mandatory NOP drain) for the SI-check harness.
module inst_stream_constraint #(
  parameter int unsigned FETCH_WIDTH       = 2,
  parameter int unsigned NUM_REGS          = 16,
  parameter int unsigned MEM_IMM_ZERO_BITS = 2,
  parameter bit          ENABLE_MUL        = 1'b1,
  parameter bit          ENABLE_BRANCH     = 1'b1,
  parameter int unsigned MAX_INSTS         = 16,
  parameter int unsigned MAX_NOP_RUN       = 4,
  parameter int unsigned DRAIN_CYCLES      = 8
) (
  input logic                     clk,
  input logic                     reset_x,
  inst_stream_constraint_if.slave bus
);
  localparam int unsigned IW = $clog2(MAX_INSTS + 1);
  localparam int unsigned NW = $clog2(MAX_NOP_RUN + 1);
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStor = 7'b0100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpNop  = 7'b1111111;

  typedef enum logic [1:0] {PhRun = 2'd0, PhDrain = 2'd1, PhDone = 2'd2} phase_e;

  phase_e        r_phase, w_phase_nxt;
  logic [IW-1:0] r_issued, w_issued_nxt;
  logic [NW-1:0] r_nop_run, w_nop_run_nxt;
  logic [DW-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic          r_done, w_done_nxt;

  logic [FETCH_WIDTH-1:0] w_slot_legal, w_is_nop, w_is_cf;
  int unsigned            w_k, w_cf_cnt, w_sum;
  logic                   w_tail_ok, w_all_nop, w_shape_ok, w_phase_ok, w_ok, w_consume;

  function automatic logic reg_ok(input logic [4:0] r);
    return 32'(r) < NUM_REGS;
  endfunction

  function automatic logic slot_is_legal(input logic [31:0] ins);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic       mem_imm_ok, ok;
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    f7  = ins[31:25];
    mem_imm_ok = (ins >> (32 - MEM_IMM_ZERO_BITS)) == 32'd0;
    ok = 1'b0;
    case (op)
      OpR: begin
        if (f7 == 7'b0000000)      ok = 1'b1;
        else if (f7 == 7'b0100000) ok = (f3 == 3'b000) || (f3 == 3'b101);
        else if (f7 == 7'b0000001) ok = ENABLE_MUL && !f3[2];
        ok = ok && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
      end
      OpI: begin
        if (f3 == 3'b001)      ok = (f7 == 7'b0000000);
        else if (f3 == 3'b101) ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   ok = 1'b1;
        ok = ok && reg_ok(rd) && reg_ok(rs1);
      end
      OpLoad: ok = (f3 == 3'b010) && reg_ok(rd) && mem_imm_ok;
      OpStor: ok = (f3 == 3'b010) && reg_ok(rs2) && mem_imm_ok;
      OpJal:  ok = 1'b1;
      OpJalr: ok = (f3 == 3'b000) && reg_ok(rd) && reg_ok(rs1);
      OpBr:   ok = ENABLE_BRANCH && (f3[2:1] != 2'b01);
      OpNop:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    w_slot_legal = '0;
    w_is_nop     = '0;
    w_is_cf      = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_slot_legal[i] = slot_is_legal(bus.instructions[32*i +: 32]);
      w_is_nop[i]     = (bus.instructions[32*i +: 7] == OpNop);
      w_is_cf[i]      = (bus.instructions[32*i +: 7] == OpJal) ||
                        (bus.instructions[32*i +: 7] == OpJalr) ||
                        (bus.instructions[32*i +: 7] == OpBr);
    end
  end

  // A NOP followed by a non-NOP anywhere breaks the contiguous NOP tail.
  always_comb begin
    w_k       = 0;
    w_cf_cnt  = 0;
    w_tail_ok = 1'b1;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!w_is_nop[i]) w_k = w_k + 1;
      if (w_is_cf[i])   w_cf_cnt = w_cf_cnt + 1;
    end
    for (int i = 1; i < FETCH_WIDTH; i++) begin
      if (w_is_nop[i-1] && !w_is_nop[i]) w_tail_ok = 1'b0;
    end
  end

  always_comb begin
    w_all_nop  = (w_k == 0);
    w_sum      = 32'(r_issued) + w_k;
    w_shape_ok = (&w_slot_legal) && w_tail_ok && (w_cf_cnt <= 1);
    if (r_phase == PhRun) begin
      w_phase_ok = (w_sum <= MAX_INSTS) && (!w_all_nop || (32'(r_nop_run) < MAX_NOP_RUN));
    end else begin
      w_phase_ok = w_all_nop;
    end
    w_ok      = w_shape_ok && w_phase_ok;
    w_consume = !bus.stall_in && w_ok;
  end

  always_comb begin
    w_phase_nxt     = r_phase;
    w_issued_nxt    = r_issued;
    w_nop_run_nxt   = r_nop_run;
    w_drain_cnt_nxt = r_drain_cnt;
    w_done_nxt      = r_done;
    if (w_consume) begin
      case (r_phase)
        PhRun: begin
          w_issued_nxt  = IW'(w_sum);
          w_nop_run_nxt = w_all_nop ? r_nop_run + NW'(1) : '0;
          if (w_sum == MAX_INSTS) begin
            w_phase_nxt     = PhDrain;
            w_drain_cnt_nxt = '0;
            w_nop_run_nxt   = '0;
          end
        end
        PhDrain: begin
          if (32'(r_drain_cnt) == DRAIN_CYCLES - 1) begin
            w_phase_nxt = PhDone;
            w_done_nxt  = 1'b1;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_phase     <= PhRun;
      r_issued    <= '0;
      r_nop_run   <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_issued    <= w_issued_nxt;
      r_nop_run   <= w_nop_run_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.slot_legal    = w_slot_legal;
  assign bus.constraint_ok = w_ok;
  assign bus.phase         = r_phase;
  assign bus.issued_cnt    = r_issued;
  assign bus.nop_run       = r_nop_run;
  assign bus.done          = r_done;

`ifdef FORMAL
  always @(posedge clk) if (reset_x) assume (w_ok);
`endif
endmodule
